// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: round-robin sharing of one byte-wide UART serializer
// between NREQ requesters. The granted frame is captured at grant and sent
// LSB-first, one byte per tx_done, with an optional per-byte watchdog.
module uart_frame_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned BYTES   = 5,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*BYTES*8-1:0]   req_data,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic                      busy,
    output logic [7:0]                tx_data,
    output logic                      tx_send_go,
    input  logic                      tx_done
);

    localparam int unsigned FW = BYTES * 8;
    localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            send_go_q, send_go_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic [LW-1:0]   last_q, last_d;
    logic [15:0]     wd_q, wd_d;

    logic            sel_valid;
    logic [LW-1:0]   sel_idx;

    // Round-robin pick: first set req bit after the previous winner, with wrap
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!sel_valid && req[LW'((32'(last_q) + k) % NREQ)]) begin
                sel_valid = 1'b1;
                sel_idx   = LW'((32'(last_q) + k) % NREQ);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        err_d      = 1'b0;
        tx_data_d  = tx_data_q;
        send_go_d  = 1'b0;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        last_d     = last_q;
        wd_d       = wd_q;

        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                    last_d     = sel_idx;
                    shift_d    = req_data[32'(sel_idx)*FW +: FW];
                    byte_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = shift_q[7:0];
                send_go_d = 1'b1;
                wd_d      = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (byte_cnt_q == CW'(BYTES - 1)) begin
                        done_d     = grant_q;
                        grant_d    = '0;
                        byte_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        shift_d    = shift_q >> 8;
                        byte_cnt_d = byte_cnt_q + CW'(1);
                        state_d    = S_LOAD;
                    end
                end else if ((TIMEOUT != 16'd0) && (wd_q == TIMEOUT - 16'd1)) begin
                    err_d      = 1'b1;
                    grant_d    = '0;
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: begin
                grant_d    = '0;
                byte_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; last_q resets so requester 0 wins first
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            send_go_q  <= 1'b0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            last_q     <= LW'(NREQ - 1);
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
            send_go_q  <= send_go_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign tx_data    = tx_data_q;
    assign tx_send_go = send_go_q;

endmodule
